// File: rtl/pos_lut_scanner.sv
// pos_lut_scanner: N-input truth-mask LUT with serial mask load, registered
// evaluation and a valid/ready enumerator of the maxterm or minterm list.
module pos_lut_scanner #(
   parameter int unsigned         N    = 4,
   parameter logic [(1<<N)-1:0]   INIT = 16'h7310
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load_en,
   input  logic         load_bit,
   input  logic [N-1:0] x,
   input  logic         in_valid,
   output logic         f,
   output logic         f_valid,
   input  logic         scan_start,
   input  logic         scan_mode,
   output logic [N-1:0] idx_out,
   output logic         idx_valid,
   input  logic         idx_ready,
   output logic         busy,
   output logic         scan_done,
   output logic [N:0]   term_count
);

   localparam int unsigned M  = 1 << N;
   localparam int unsigned CW = N + 1;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t         state_q, state_d;
   logic [M-1:0]   mask_q, mask_d;
   logic [M-1:0]   snap_q, snap_d;
   logic           mode_q, mode_d;
   logic [N-1:0]   idx_q, idx_d;
   logic           idx_valid_q, idx_valid_d;
   logic [CW-1:0]  count_q, count_d;
   logic [CW-1:0]  term_count_q, term_count_d;
   logic           busy_q, busy_d;
   logic           scan_done_q, scan_done_d;
   logic           f_q, f_d;
   logic           f_valid_q, f_valid_d;

   // State and output registers; reset restores the INIT mask and aborts any scan.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         mask_q       <= INIT;
         snap_q       <= '0;
         mode_q       <= 1'b0;
         idx_q        <= '0;
         idx_valid_q  <= 1'b0;
         count_q      <= '0;
         term_count_q <= '0;
         busy_q       <= 1'b0;
         scan_done_q  <= 1'b0;
         f_q          <= 1'b0;
         f_valid_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         mask_q       <= mask_d;
         snap_q       <= snap_d;
         mode_q       <= mode_d;
         idx_q        <= idx_d;
         idx_valid_q  <= idx_valid_d;
         count_q      <= count_d;
         term_count_q <= term_count_d;
         busy_q       <= busy_d;
         scan_done_q  <= scan_done_d;
         f_q          <= f_d;
         f_valid_q    <= f_valid_d;
      end
   end

   // Next-state logic: evaluation in every state, load and scan sequencing by FSM state.
   always_comb begin
      state_d      = state_q;
      mask_d       = mask_q;
      snap_d       = snap_q;
      mode_d       = mode_q;
      idx_d        = idx_q;
      idx_valid_d  = idx_valid_q;
      count_d      = count_q;
      term_count_d = term_count_q;
      busy_d       = busy_q;
      scan_done_d  = 1'b0;
      f_valid_d    = in_valid;
      f_d          = in_valid ? mask_q[x] : f_q;

      case (state_q)
         IDLE: begin
            if (load_en) begin
               mask_d = {mask_q[M-2:0], load_bit};
            end
            // Snapshot the pre-shift mask so a same-edge load cannot alter this scan.
            if (scan_start) begin
               state_d     = SCAN;
               mode_d      = scan_mode;
               snap_d      = mask_q;
               idx_d       = '0;
               idx_valid_d = (mask_q[0] == scan_mode);
               count_d     = '0;
               busy_d      = 1'b1;
            end
         end
         SCAN: begin
            // idx_valid_q already reflects whether idx_q matches; only a stall holds the index.
            if (!(idx_valid_q && !idx_ready)) begin
               if (idx_valid_q) begin
                  count_d = count_q + CW'(1);
               end
               if (idx_q == N'(M - 1)) begin
                  state_d      = DONE;
                  idx_valid_d  = 1'b0;
                  scan_done_d  = 1'b1;
                  term_count_d = count_d;
               end else begin
                  idx_d       = idx_q + N'(1);
                  idx_valid_d = (snap_q[idx_d] == mode_q);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign f          = f_q;
   assign f_valid    = f_valid_q;
   assign idx_out    = idx_q;
   assign idx_valid  = idx_valid_q;
   assign busy       = busy_q;
   assign scan_done  = scan_done_q;
   assign term_count = term_count_q;

endmodule

// File: tb/tb_pos_lut_scanner.sv
// Self-checking bench for pos_lut_scanner (N=4): directed and randomized steps
// against a truth-table / term-list reference model.
module tb_pos_lut_scanner;

   localparam int unsigned N = 4;
   localparam int unsigned M = 16;
   localparam logic [15:0] INIT = 16'h7310;

   logic         clk = 1'b0;
   logic         reset;
   logic         load_en, load_bit, in_valid, scan_start, scan_mode, idx_ready;
   logic [N-1:0] x;
   logic         f, f_valid, idx_valid, busy, scan_done;
   logic [N-1:0] idx_out;
   logic [N:0]   term_count;

   int           checks = 0;
   int           errors = 0;
   logic [15:0]  model;
   logic         exp_f;
   logic [3:0]   fixed_x [4];

   always #5 clk = ~clk;

   pos_lut_scanner #(.N(N), .INIT(INIT)) dut (
      .clk        (clk),
      .reset      (reset),
      .load_en    (load_en),
      .load_bit   (load_bit),
      .x          (x),
      .in_valid   (in_valid),
      .f          (f),
      .f_valid    (f_valid),
      .scan_start (scan_start),
      .scan_mode  (scan_mode),
      .idx_out    (idx_out),
      .idx_valid  (idx_valid),
      .idx_ready  (idx_ready),
      .busy       (busy),
      .scan_done  (scan_done),
      .term_count (term_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Serially shift nbits of w, MSB first; the model follows the shift rule.
   task automatic load_bits(input logic [15:0] w, input int nbits);
      for (int i = nbits - 1; i >= 0; i--) begin
         load_en  = 1'b1;
         load_bit = w[i];
         @(negedge clk);
         model = (model << 1) | 16'(w[i]);
      end
      load_en = 1'b0;
   endtask

   // Back-to-back evaluations; result of each request is checked one cycle later.
   task automatic eval_burst(input int cnt, input bit rnd);
      logic       pend = 1'b0;
      logic [3:0] xv;
      logic       iv, ld, lb;
      for (int i = 0; i <= cnt; i++) begin
         if (i > 0) begin
            check("f_valid", 32'(f_valid), 32'(pend));
            check("f", 32'(f), 32'(exp_f));
         end
         if (i < cnt) begin
            xv = rnd ? 4'($urandom) : fixed_x[i];
            iv = rnd ? 1'($urandom) : 1'b1;
            ld = rnd && ($urandom % 4 == 0);
            lb = 1'($urandom);
            x = xv; in_valid = iv; load_en = ld; load_bit = lb;
            if (iv) exp_f = model[xv];
            if (ld) model = (model << 1) | 16'(lb);
            pend = iv;
            @(negedge clk);
         end
      end
      in_valid = 1'b0;
      load_en  = 1'b0;
   endtask

   // One full scan; kind 0: ready tied high, 1: ready 1-of-3, 2: random ready.
   task automatic do_scan(input logic mode, input int kind, input bit inject);
      int         q[$];
      int         stalls = 0, tick = 0, cyc = 1, exp_n;
      bit         done = 1'b0, prev_stall = 1'b0;
      logic [3:0] prev_idx = '0;
      logic       rdy;
      for (int i = 0; i < int'(M); i++) if (model[i] == mode) q.push_back(i);
      exp_n = q.size();
      idx_ready  = 1'b0;
      scan_start = 1'b1;
      scan_mode  = mode;
      @(negedge clk);
      scan_start = 1'b0;
      scan_mode  = 1'($urandom);
      while (!done && cyc < 300) begin
         if (scan_done === 1'b1) begin
            check("done_cycles", 32'(cyc), 32'(int'(M) + stalls + 1));
            check("term_count", 32'(term_count), 32'(exp_n));
            check("terms_left", 32'(q.size()), 32'd0);
            check("idx_valid_in_done", 32'(idx_valid), 32'd0);
            done = 1'b1;
         end else begin
            check("busy_in_scan", 32'(busy), 32'd1);
            if (prev_stall) begin
               check("valid_held", 32'(idx_valid), 32'd1);
               check("idx_stable", 32'(idx_out), 32'(prev_idx));
            end
            case (kind)
               0:       rdy = 1'b1;
               1:       rdy = (tick % 3 == 0);
               default: rdy = 1'($urandom);
            endcase
            tick++;
            if (idx_valid === 1'b1) begin
               if (q.size() == 0) begin
                  check("idx_valid_extra", 32'(idx_valid), 32'd0);
               end else begin
                  check("idx_out", 32'(idx_out), 32'(q[0]));
                  if (rdy) void'(q.pop_front());
                  else stalls++;
               end
               prev_stall = !rdy;
               prev_idx   = idx_out;
            end else begin
               prev_stall = 1'b0;
            end
            idx_ready = rdy;
            if (inject && cyc == 3) begin
               load_en = 1'b1; load_bit = 1'b0; scan_start = 1'b1; scan_mode = ~mode;
            end else begin
               load_en = 1'b0; scan_start = 1'b0;
            end
            @(negedge clk);
            cyc++;
         end
      end
      if (!done) check("scan_timeout", 32'(done), 32'd1);
      idx_ready = 1'b0; load_en = 1'b0; scan_start = 1'b0;
      @(negedge clk);
      check("busy_after", 32'(busy), 32'd0);
      check("done_pulse_width", 32'(scan_done), 32'd0);
      check("term_count_hold", 32'(term_count), 32'(exp_n));
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      int seen;
      reset = 1'b1; load_en = 1'b0; load_bit = 1'b0; x = '0; in_valid = 1'b0;
      scan_start = 1'b0; scan_mode = 1'b0; idx_ready = 1'b0;
      model = INIT; exp_f = 1'b0;
      fixed_x[0] = 4'b0100; fixed_x[1] = 4'b0000; fixed_x[2] = 4'b1110; fixed_x[3] = 4'b1111;
      repeat (2) @(negedge clk);
      check("rst_f", 32'(f), 0);
      check("rst_f_valid", 32'(f_valid), 0);
      check("rst_idx_out", 32'(idx_out), 0);
      check("rst_idx_valid", 32'(idx_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_scan_done", 32'(scan_done), 0);
      check("rst_term_count", 32'(term_count), 0);
      reset = 1'b0;
      @(negedge clk);

      // Default mask: f = 1,0,1,0 for x = 4,0,14,15.
      eval_burst(4, 1'b0);
      // Maxterms with ready tied high: 10 terms.
      do_scan(1'b0, 0, 1'b0);
      // Minterms with 1-of-3 ready: 6 terms.
      do_scan(1'b1, 1, 1'b0);
      // Load and scan_start during a scan must be ignored.
      do_scan(1'b0, 2, 1'b1);
      eval_burst(4, 1'b0);

      // All-ones mask: no maxterms, 16 minterms.
      load_bits(16'hFFFF, 16);
      do_scan(1'b0, 0, 1'b0);
      do_scan(1'b1, 0, 1'b0);

      // Random masks, partial loads, evaluations with same-edge shifts, scans.
      for (int r = 0; r < 6; r++) begin
         if (r % 2 == 0) load_bits(16'($urandom), 16);
         else            load_bits(16'($urandom), int'($urandom_range(1, 7)));
         eval_burst(12, 1'b1);
         do_scan(1'($urandom), 2, 1'b0);
      end

      // Reset in the middle of a scan while idx 5 is presented.
      load_bits(16'h7300, 16);
      found = 1'b0;
      idx_ready = 1'b1; scan_start = 1'b1; scan_mode = 1'b0;
      @(negedge clk);
      scan_start = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         if (idx_valid === 1'b1 && idx_out == 4'd5) found = 1'b1;
         else @(negedge clk);
      end
      check("reach_idx5", 32'(found), 1);
      idx_ready = 1'b0;
      #2 reset = 1'b1;
      #1;
      check("arst_idx_valid", 32'(idx_valid), 0);
      check("arst_idx_out", 32'(idx_out), 0);
      check("arst_busy", 32'(busy), 0);
      check("arst_f", 32'(f), 0);
      check("arst_f_valid", 32'(f_valid), 0);
      check("arst_term_count", 32'(term_count), 0);
      @(negedge clk);
      reset = 1'b0;
      model = INIT; exp_f = 1'b0;
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (scan_done === 1'b1) seen++;
      end
      check("no_done_after_reset", 32'(seen), 0);
      check("idle_after_reset", 32'(busy), 0);
      eval_burst(4, 1'b0);
      do_scan(1'b0, 1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pos_lut_scanner.md
Name: pos_lut_scanner

Overview:
- Parametrised successor to the fixed 4-input canonical PoS/SoP blocks.
- Holds an N-input Boolean function as a 2^N-bit truth mask (bit i = f at input index i). The mask is loadable at run time over a serial shift port.
- Evaluates f for any input vector with a registered output.
- Enumerates the canonical maxterm list (PoS) or minterm list (SoP) sequentially over a valid/ready stream, then reports the term count.

Parameters:
- N, 4, number of function inputs (legal 2..8); x[N-1] is the MSB (A in the 4-input naming).
- INIT, 16'h7310 (width 2^N), reset value of the truth mask. Default gives f=0 at maxterms 0,1,2,3,5,6,7,10,11,15.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- load_en  in  1  shift one mask bit this cycle.
- load_bit  in  1  serial mask data. Shift is mask <= {mask[2^N-2:0], load_bit}, so the MSB is sent first.
- x  in  N  input vector to evaluate.
- in_valid  in  1  evaluate x this cycle.
- f  out  1  registered function value.
- f_valid  out  1  one-cycle pulse qualifying f.
- scan_start  in  1  begin enumeration (sampled in IDLE only).
- scan_mode  in  1  0 = list maxterms (f=0); 1 = list minterms (f=1). Sampled with scan_start.
- idx_out  out  N  current term index.
- idx_valid  out  1  idx_out valid.
- idx_ready  in  1  consumer accepts idx_out.
- busy  out  1  high in SCAN and DONE.
- scan_done  out  1  one-cycle pulse at end of scan.
- term_count  out  N+1  number of terms emitted by the last scan; held until the next scan_start.

Behaviour:
- Reset (async, any state): mask=INIT, state=IDLE, f=0, f_valid=0, idx_out=0, idx_valid=0, busy=0, scan_done=0, term_count=0, index counter=0.
- Evaluation, legal in any state:
  - in_valid=1 at edge k gives f=mask[x] and f_valid=1 after edge k (latency 1).
  - in_valid=0 gives f_valid=0 and f holds its value.
  - Evaluation uses the mask value before any shift occurring on the same edge.
- Load: accepted only in IDLE. load_en in SCAN or DONE is ignored. Loading 2^N bits fully replaces the mask; there is no bit counter, and a partial load leaves a partially shifted mask.
- FSM states IDLE, SCAN, DONE.
  - IDLE -> SCAN on scan_start: latch mode, snapshot the mask into the scan register, index i=0, count=0, busy=1. scan_start outside IDLE is ignored.
  - SCAN, one index examined per cycle. An index matches when snapshot[i] == scan_mode.
    - No match and i<2^N-1: i++.
    - Match: idx_out=i, idx_valid=1, held stable until a cycle with idx_ready=1. On that edge count++; then i++, or go to DONE if i was 2^N-1.
    - No match at i=2^N-1: go to DONE.
    - idx_valid never deasserts without a handshake. idx_out is unchanged while idx_valid=1 and idx_ready=0.
  - DONE (1 cycle): scan_done=1, term_count=count, idx_valid=0, then IDLE with busy=0.
- Latency: a scan takes 2^N + (handshake stall cycles) + 1 cycles from scan_start to scan_done.
- Counter width: count is N+1 bits, so an all-match scan yields term_count=2^N without wrap.
- Zero matches: no idx_valid pulses; scan_done after 2^N+1 cycles; term_count=0.
- idx_ready asserted while idx_valid=0 has no effect.
- Reset mid-scan aborts the scan: no scan_done pulse, term_count=0.

Test Plan:
- Reset with default INIT; drive x=4'b0100, 4'b0000, 4'b1110, 4'b1111 with in_valid -> f=1,0,1,0 one cycle later, f_valid pulsing each cycle.
- scan_mode=0, idx_ready tied 1 -> idx_out sequence 0,1,2,3,5,6,7,10,11,15; scan_done after 17 cycles; term_count=10.
- scan_mode=1, idx_ready toggling 1-of-3 cycles -> sequence 4,8,9,12,13,14; idx_out stable during stalls; term_count=6.
- Shift in 16 ones (load_en=1), then maxterm scan -> no idx_valid; scan_done 17 cycles after start; term_count=0. Minterm scan -> 16 terms; term_count=16 (5'b10000).
- During a scan, pulse load_en with bit 0 and pulse scan_start -> mask unchanged afterwards (x=4'b0100 still gives f=1), and the scan is not restarted.
- Assert reset while idx_valid=1 at idx_out=5 -> all outputs 0 immediately (asynchronous), mask=16'h7310, no scan_done; a fresh scan completes normally.
